fb_write_scheduler: RTL and testbench

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/fb_write_scheduler.sv | 137 +++++++++++++
 tb/tb_fb_write_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port scheduler: round-robin arbitration of three pixel writers plus
// a full-screen clear sweep that owns the write port while it runs.
module fb_write_scheduler #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 384,
  parameter int unsigned AW     = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_start,
  input  logic [11:0]          clear_color,
  input  logic [2:0]           req_valid,
  input  logic [2:0][10:0]     req_x,
  input  logic [2:0][9:0]      req_y,
  input  logic [2:0][11:0]     req_pixel,
  output logic [2:0]           req_ready,
  output logic [AW-1:0]        fb_addr,
  output logic [11:0]          fb_data,
  output logic                 fb_we,
  output logic                 clear_busy,
  output logic                 frame_done,
  output logic [15:0]          drop_count
);

  localparam int unsigned   NPix     = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LastAddr = AW'(NPix - 1);

  typedef enum logic [0:0] {StArb, StClear} state_e;

  state_e      state_q;
  logic [1:0]  ptr_q;

  logic [2:0]  gnt;
  logic [1:0]  gnt_idx;
  logic [1:0]  idx;
  logic [2:0]  sum;
  logic        found;
  logic        arb_en;
  logic        accept;
  logic [10:0] sel_x;
  logic [9:0]  sel_y;
  logic [11:0] sel_pixel;
  logic        on_screen;
  logic [31:0] lin_addr;
  logic [1:0]  ptr_nxt;

  // Search from the pointer upward (mod 3) for the first valid requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    sum     = '0;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr_q} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) gnt = 3'b001 << gnt_idx;
  end

  // A pending clear always wins over requesters in the same cycle.
  assign arb_en    = (state_q == StArb) && !clear_start && !rst_in;
  assign req_ready = arb_en ? gnt : 3'b000;
  assign accept    = |req_ready;

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_pixel = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_x     = req_x[i];
        sel_y     = req_y[i];
        sel_pixel = req_pixel[i];
      end
    end
  end

  assign on_screen = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);
  assign lin_addr  = 32'(sel_x) + 32'(sel_y) * WIDTH;
  assign ptr_nxt   = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StArb;
      ptr_q      <= 2'd0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_busy <= 1'b0;
      frame_done <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        StArb: begin
          if (clear_start) begin
            // fb_data keeps the fill colour for the whole sweep.
            state_q    <= StClear;
            fb_we      <= 1'b1;
            fb_addr    <= '0;
            fb_data    <= clear_color;
            clear_busy <= 1'b1;
          end else begin
            fb_we <= 1'b0;
            if (accept) begin
              ptr_q <= ptr_nxt;
              if (on_screen) begin
                fb_we   <= 1'b1;
                fb_addr <= AW'(lin_addr);
                fb_data <= sel_pixel;
              end else if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
            end
          end
        end
        StClear: begin
          if (fb_addr == LastAddr) begin
            state_q    <= StArb;
            fb_we      <= 1'b0;
            clear_busy <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            fb_addr <= fb_addr + AW'(1);
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Directed bench: a default-size instance for arbitration/drop behaviour and a 4x2 instance
// for the clear sweep and reset-abort cases.
module tb_fb_write_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            cs_big, cs_small;
  logic [11:0]     color;
  logic [2:0]      valid;
  logic [2:0][10:0] rx;
  logic [2:0][9:0]  ry;
  logic [2:0][11:0] rp;

  logic [2:0]  ready_b, ready_s;
  logic [17:0] addr_b;
  logic [2:0]  addr_s;
  logic [11:0] data_b, data_s;
  logic        we_b, we_s, busy_b, busy_s, fd_b, fd_s;
  logic [15:0] drop_b, drop_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_write_scheduler u_big (
    .clk_in(clk), .rst_in(rst), .clear_start(cs_big), .clear_color(color),
    .req_valid(valid), .req_x(rx), .req_y(ry), .req_pixel(rp),
    .req_ready(ready_b), .fb_addr(addr_b), .fb_data(data_b), .fb_we(we_b),
    .clear_busy(busy_b), .frame_done(fd_b), .drop_count(drop_b)
  );

  fb_write_scheduler #(.WIDTH(4), .HEIGHT(2)) u_small (
    .clk_in(clk), .rst_in(rst), .clear_start(cs_small), .clear_color(color),
    .req_valid(valid), .req_x(rx), .req_y(ry), .req_pixel(rp),
    .req_ready(ready_s), .fb_addr(addr_s), .fb_data(data_s), .fb_we(we_s),
    .clear_busy(busy_s), .frame_done(fd_s), .drop_count(drop_s)
  );

  typedef struct {
    logic [2:0]       valid;
    logic [2:0][10:0] x;
    logic [2:0][9:0]  y;
    logic [2:0][11:0] p;
    logic [2:0]       ready;
    logic             we;
    logic [17:0]      addr;
    logic [11:0]      data;
    logic [15:0]      drop;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] v,
                              input int x0, input int y0, input int p0,
                              input int x1, input int y1, input int p1,
                              input int x2, input int y2, input int p2,
                              input logic [2:0] r, input logic w, input int a,
                              input int d, input int dr);
    vec_t t;
    t.valid = v;
    t.x[0] = 11'(x0); t.y[0] = 10'(y0); t.p[0] = 12'(p0);
    t.x[1] = 11'(x1); t.y[1] = 10'(y1); t.p[1] = 12'(p1);
    t.x[2] = 11'(x2); t.y[2] = 10'(y2); t.p[2] = 12'(p2);
    t.ready = r; t.we = w; t.addr = 18'(a); t.data = 12'(d); t.drop = 16'(dr);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    valid = 3'b000;
    cs_small = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    logic seen_fd;
    rst = 1'b1; cs_big = 1'b0; cs_small = 1'b0; color = '0;
    valid = 3'b111; rx = '0; ry = '0; rp = '0;

    // Reset state, with requests pending.
    #1;
    chk("rst_ready_b", 32'(ready_b), 32'h0);
    chk("rst_ready_s", 32'(ready_s), 32'h0);
    chk("rst_we", 32'(we_b), 32'h0);
    chk("rst_addr", 32'(addr_b), 32'h0);
    chk("rst_data", 32'(data_b), 32'h0);
    chk("rst_drop", 32'(drop_b), 32'h0);
    chk("rst_busy", 32'(busy_s), 32'h0);
    chk("rst_fd", 32'(fd_s), 32'h0);
    tick(); tick();
    chk("rst_hold_we", 32'(we_b), 32'h0);
    rst = 1'b0;

    vecs[0]  = mk(3'b111, 1, 0, 'h111, 2, 0, 'h222, 3, 0, 'h333, 3'b001, 1, 1, 'h111, 0);
    vecs[1]  = mk(3'b111, 1, 0, 'h111, 2, 0, 'h222, 3, 0, 'h333, 3'b010, 1, 2, 'h222, 0);
    vecs[2]  = mk(3'b111, 1, 0, 'h111, 2, 0, 'h222, 3, 0, 'h333, 3'b100, 1, 3, 'h333, 0);
    vecs[3]  = mk(3'b111, 1, 0, 'h111, 2, 0, 'h222, 3, 0, 'h333, 3'b001, 1, 1, 'h111, 0);
    vecs[4]  = mk(3'b010, 0, 0, 0, 5, 2, 'hABC, 0, 0, 0, 3'b010, 1, 1029, 'hABC, 0);
    vecs[5]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1029, 'hABC, 0);
    vecs[6]  = mk(3'b011, 512, 0, 'h777, 7, 7, 'h777, 0, 0, 0, 3'b001, 0, 1029, 'hABC, 1);
    vecs[7]  = mk(3'b011, 512, 0, 'h777, 511, 383, 'hFFF, 0, 0, 0, 3'b010, 1, 196607, 'hFFF, 1);
    vecs[8]  = mk(3'b101, 0, 0, 'h123, 0, 0, 0, 0, 384, 'h456, 3'b100, 0, 196607, 'hFFF, 2);
    vecs[9]  = mk(3'b100, 0, 0, 0, 0, 0, 0, 10, 1, 'h5A5, 3'b100, 1, 522, 'h5A5, 2);
    vecs[10] = mk(3'b110, 0, 0, 0, 0, 0, 'h001, 9, 9, 'h999, 3'b010, 1, 0, 'h001, 2);
    vecs[11] = mk(3'b111, 3, 0, 'hAAA, 4, 0, 'hBBB, 6, 0, 'hCCC, 3'b100, 1, 6, 'hCCC, 2);

    for (int i = 0; i < 12; i++) begin
      valid = vecs[i].valid; rx = vecs[i].x; ry = vecs[i].y; rp = vecs[i].p;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(ready_b), 32'(vecs[i].ready));
      tick();
      chk($sformatf("v%0d_we", i), 32'(we_b), 32'(vecs[i].we));
      chk($sformatf("v%0d_addr", i), 32'(addr_b), 32'(vecs[i].addr));
      chk($sformatf("v%0d_data", i), 32'(data_b), 32'(vecs[i].data));
      chk($sformatf("v%0d_drop", i), 32'(drop_b), 32'(vecs[i].drop));
    end

    // Clear sweep on the 4x2 instance.
    pulse_reset();
    cs_small = 1'b1; color = 12'h100;
    tick();
    cs_small = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clr%0d_we", i), 32'(we_s), 32'h1);
      chk($sformatf("clr%0d_addr", i), 32'(addr_s), 32'(i));
      chk($sformatf("clr%0d_data", i), 32'(data_s), 32'h100);
      chk($sformatf("clr%0d_busy", i), 32'(busy_s), 32'h1);
      chk($sformatf("clr%0d_fd", i), 32'(fd_s), 32'h0);
      tick();
    end
    chk("clr_fd", 32'(fd_s), 32'h1);
    chk("clr_end_we", 32'(we_s), 32'h0);
    chk("clr_end_busy", 32'(busy_s), 32'h0);
    tick();
    chk("clr_fd_pulse", 32'(fd_s), 32'h0);

    // Clear racing with requests: clear wins, no writes leak in until frame_done.
    pulse_reset();
    valid = 3'b111;
    rx[0] = 11'd1; ry[0] = 10'd1; rp[0] = 12'h0A1;
    rx[1] = 11'd2; ry[1] = 10'd0; rp[1] = 12'h0B2;
    rx[2] = 11'd3; ry[2] = 10'd0; rp[2] = 12'h0C3;
    cs_small = 1'b1; color = 12'h3C3;
    #1;
    chk("race_ready", 32'(ready_s), 32'h0);
    tick();
    cs_small = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("race%0d_ready", i), 32'(ready_s), 32'h0);
      chk($sformatf("race%0d_addr", i), 32'(addr_s), 32'(i));
      chk($sformatf("race%0d_data", i), 32'(data_s), 32'h3C3);
      tick();
    end
    chk("race_fd", 32'(fd_s), 32'h1);
    chk("race_fd_ready", 32'(ready_s), 32'h1);
    tick();
    chk("race_post_we", 32'(we_s), 32'h1);
    chk("race_post_addr", 32'(addr_s), 32'h5);
    chk("race_post_data", 32'(data_s), 32'h0A1);

    // Reset in the middle of a sweep.
    pulse_reset();
    cs_small = 1'b1; color = 12'h222;
    tick();
    cs_small = 1'b0;
    tick(); tick(); tick();
    chk("abort_pre_addr", 32'(addr_s), 32'h3);
    chk("abort_pre_busy", 32'(busy_s), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_we", 32'(we_s), 32'h0);
    chk("abort_busy", 32'(busy_s), 32'h0);
    chk("abort_addr", 32'(addr_s), 32'h0);
    tick();
    rst = 1'b0;
    seen_fd = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_fd = seen_fd | fd_s;
      tick();
    end
    chk("abort_no_fd", 32'(seen_fd), 32'h0);
    valid = 3'b001; rx[0] = 11'd0; ry[0] = 10'd0; rp[0] = 12'h0F0;
    #1;
    chk("abort_arb_ready", 32'(ready_s), 32'h1);
    tick();
    chk("abort_arb_we", 32'(we_s), 32'h1);
    chk("abort_arb_data", 32'(data_s), 32'h0F0);

    // Drop counter saturation on the default-size instance.
    pulse_reset();
    valid = 3'b001; rx[0] = 11'd512; ry[0] = 10'd0; rp[0] = 12'h777;
    #1;
    chk("sat_ready", 32'(ready_b), 32'h1);
    tick();
    chk("sat_first", 32'(drop_b), 32'h1);
    chk("sat_we", 32'(we_b), 32'h0);
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(drop_b), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(drop_b), 32'hFFFF);
    tick();
    chk("sat_hold", 32'(drop_b), 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
